mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port main-memory block RAM (1-cycle read latency) between two requesters:
//  - The CPU MEM-stage data port (CPU).
//  - The sprite/frame fetch engine (SPR).
//  Arbitration is round-robin; SPR may lock a bounded burst. Grants are same-cycle, so one RAM access
//  can issue per cycle. The block drives the RAM enable/write/address/data pins and returns a read-valid
//  pulse to the winning requester. cpu_stall feeds the pipeline hazard unit.
// PARAMETERS
//  ADDR_W     5   RAM word-address width
//  DATA_W     32  data width
//  MAX_BURST  8   max consecutive SPR grants under lock (>=1)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  cpu_req      in   1       CPU access request; hold req/we/addr/wdata stable until cpu_gnt
//  cpu_we       in   1       1=write, 0=read
//  cpu_addr     in   ADDR_W  word address
//  cpu_wdata    in   DATA_W  write data
//  cpu_gnt      out  1       access issued to RAM this cycle
//  cpu_stall    out  1       cpu_req & ~cpu_gnt
//  cpu_rvalid   out  1       cpu_rdata valid (read granted previous cycle)
//  cpu_rdata    out  DATA_W  read data (=ram_dout)
//  spr_req/spr_we/spr_addr/spr_wdata  in  1/1/ADDR_W/DATA_W  same semantics as CPU
//  spr_lock     in   1       request burst ownership while asserted
//  spr_gnt      out  1       access issued this cycle
//  spr_rvalid   out  1       spr_rdata valid
//  spr_rdata    out  DATA_W  read data (=ram_dout)
//  ram_en       out  1       RAM enable (any grant)
//  ram_we       out  1       RAM write enable
//  ram_addr     out  ADDR_W  RAM address from granted requester
//  ram_din      out  DATA_W  RAM write data from granted requester
//  ram_dout     in   DATA_W  RAM read data, valid cycle after ram_en & ~ram_we
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//  - state=IDLE, last_owner=SPR (CPU wins the first tie), burst_cnt=0, both rvalid=0.
//  - All grant and RAM outputs are combinational and are 0 while no req is asserted.
//  - A pending read in flight at reset is dropped; no rvalid follows it.
//  Grant (combinational, same cycle as req):
//  - At most one gnt per cycle; ram_* is muxed from the granted requester.
//  - ram_en=0 when neither requester is granted.
//  States:
//  - IDLE: no grant last cycle.
//  - SERVE: a non-burst grant occurred last cycle.
//  - BURST: SPR owns the RAM.
//  Arbitration outside BURST:
//  - If only one requester, it wins.
//  - If both request, the requester != last_owner wins.
//  - last_owner updates on every grant.
//  Burst entry:
//  - An SPR grant with spr_lock=1 -> BURST, burst_cnt=1.
//  - If MAX_BURST=1, go straight to cooldown instead of BURST.
//  In BURST:
//  - spr_req&spr_lock -> SPR granted regardless of cpu_req; burst_cnt++.
//  - burst_cnt==MAX_BURST after a grant -> exit to SERVE with a 1-cycle cooldown. In the cooldown cycle
//    SPR is masked if cpu_req=1; if cpu_req=0, SPR may be granted but cannot re-lock that cycle.
//  - spr_lock=0 or spr_req=0 -> leave BURST this cycle; normal arbitration applies in the same cycle.
//  - CPU wait bound: at most MAX_BURST cycles after cpu_req rises.
//  Read return:
//  - x_rvalid is registered: 1 in cycle N+1 iff x was granted a read (we=0) in cycle N.
//  - Writes never produce rvalid.
//  - rvalid is a 1-cycle pulse per read; back-to-back reads give consecutive pulses.
//  Simultaneous/edge cases:
//  - A requester dropping req before gnt is allowed; there is no side effect.
//  - Same-address write then read in consecutive cycles returns the new data (RAM write-first).
//  - Address overflow is impossible; addr is taken as-is at ADDR_W bits.
// STRUCTURE
//  - Package mem_arb_pkg holds:
//    - the owner enum (OWN_CPU=0, OWN_SPR=1);
//    - state encodings (IDLE=2'd0, SERVE=2'd1, BURST=2'd2);
//    - default ADDR_W/DATA_W/MAX_BURST constants.
//  - Sub-module rr_arb2: 2-way round-robin with last_owner register and mask input.
//  - Top holds the FSM, burst counter, cooldown flag, request/RAM muxing and rvalid registers.
// TESTING
//  1. Reset, then CPU read addr 5 alone -> cpu_gnt same cycle, ram_addr=5, cpu_rvalid=1 next cycle with
//     preloaded 0xDEADBEEF; spr_rvalid stays 0.
//  2. Both req every cycle, no lock -> grants alternate CPU,SPR,CPU,...; first grant CPU; cpu_stall=1 on
//     SPR cycles.
//  3. SPR lock with 12 reads while cpu_req held (MAX_BURST=8) -> 8 SPR grants, then CPU granted,
//     then SPR resumes; CPU wait is exactly 8 cycles.
//  4. CPU write 0x12345678 to addr 3 then SPR read addr 3 -> ram_we=1 then 0; spr_rdata=0x12345678;
//     no cpu_rvalid.
//  5. rst asserted the cycle after an SPR read grant -> spr_rvalid=0, state IDLE, next tie goes to CPU.
//  6. spr_lock drops mid-burst with cpu_req=1 -> CPU granted that same cycle; burst_cnt cleared.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
// Owner and FSM encodings are fixed so that debug taps stay stable across builds.
package mem_arb_pkg;

    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 8;

    // Width of the debug burst counter exported on the interface.
    localparam int DBG_CNT_W = 8;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_SPR = 1'b1
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        BURST = 2'd2
    } state_t;

    // Counter width able to hold the value max_burst itself.
    function automatic int burst_cnt_w(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU port, SPR port and RAM pins around the arbiter.
// Handshake: a requester holds req/we/addr/wdata until it sees gnt in the same cycle; rvalid follows a read grant by one cycle.
interface mem_port_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              spr_req;
    logic              spr_we;
    logic [ADDR_W-1:0] spr_addr;
    logic [DATA_W-1:0] spr_wdata;
    logic              spr_lock;
    logic              spr_gnt;
    logic              spr_rvalid;
    logic [DATA_W-1:0] spr_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    state_t            dbg_state;
    logic [DBG_CNT_W-1:0] dbg_burst_cnt;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  spr_req, spr_we, spr_addr, spr_wdata, spr_lock,
        output spr_gnt, spr_rvalid, spr_rdata,
        output ram_en, ram_we, ram_addr, ram_din,
        input  ram_dout,
        output dbg_state, dbg_burst_cnt
    );

    // Requester / RAM-model side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output spr_req, spr_we, spr_addr, spr_wdata, spr_lock,
        input  spr_gnt, spr_rvalid, spr_rdata,
        input  ram_en, ram_we, ram_addr, ram_din,
        output ram_dout,
        input  dbg_state, dbg_burst_cnt
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: ties go to the requester that did not win last.
// A forced SPR grant (burst hold) bypasses arbitration but still updates the owner history.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_cpu,
    input  logic i_req_spr,
    input  logic i_mask_spr,
    input  logic i_force_spr,
    output logic o_gnt_cpu,
    output logic o_gnt_spr
);

    owner_t r_last_owner;
    logic   w_spr_ok;

    always_comb begin
        o_gnt_cpu = 1'b0;
        o_gnt_spr = 1'b0;
        w_spr_ok  = i_req_spr & ~i_mask_spr;
        if (i_force_spr) begin
            o_gnt_spr = 1'b1;
        end else if (i_req_cpu && w_spr_ok) begin
            if (r_last_owner == OWN_SPR) begin
                o_gnt_cpu = 1'b1;
            end else begin
                o_gnt_spr = 1'b1;
            end
        end else if (i_req_cpu) begin
            o_gnt_cpu = 1'b1;
        end else if (w_spr_ok) begin
            o_gnt_spr = 1'b1;
        end
    end

    // Reset to SPR so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= OWN_SPR;
        end else if (o_gnt_cpu) begin
            r_last_owner <= OWN_CPU;
        end else if (o_gnt_spr) begin
            r_last_owner <= OWN_SPR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port, 1-cycle-latency block RAM between the CPU data port and the sprite fetch engine.
// Round-robin arbitration with a bounded SPR burst lock followed by a one-cycle CPU-priority cooldown.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic        clk,
    input  logic        rst,
    mem_port_if.slave   bus
);

    localparam int CNT_W = burst_cnt_w(MAX_BURST);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] w_burst_cnt_nxt;
    logic             r_cool;
    logic             w_cool_nxt;
    logic             r_cpu_rvalid;
    logic             r_spr_rvalid;

    logic             w_hold;
    logic             w_mask_spr;
    logic             w_gnt_cpu;
    logic             w_gnt_spr;

    // Burst continues only while SPR keeps both req and lock asserted.
    assign w_hold     = (r_state == BURST) & bus.spr_req & bus.spr_lock;
    assign w_mask_spr = r_cool & bus.cpu_req;

    rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req_cpu   (bus.cpu_req),
        .i_req_spr   (bus.spr_req),
        .i_mask_spr  (w_mask_spr),
        .i_force_spr (w_hold),
        .o_gnt_cpu   (w_gnt_cpu),
        .o_gnt_spr   (w_gnt_spr)
    );

    always_comb begin
        w_state_nxt     = IDLE;
        w_burst_cnt_nxt = '0;
        w_cool_nxt      = 1'b0;
        if (w_gnt_spr && w_hold) begin
            if (r_burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                w_state_nxt = SERVE;
                w_cool_nxt  = 1'b1;
            end else begin
                w_state_nxt     = BURST;
                w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            end
        end else if (w_gnt_spr && bus.spr_lock && !r_cool) begin
            // A lock request during cooldown is ignored for one cycle.
            if (MAX_BURST == 1) begin
                w_state_nxt = SERVE;
                w_cool_nxt  = 1'b1;
            end else begin
                w_state_nxt     = BURST;
                w_burst_cnt_nxt = CNT_W'(1);
            end
        end else if (w_gnt_spr || w_gnt_cpu) begin
            w_state_nxt = SERVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_burst_cnt  <= '0;
            r_cool       <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_spr_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_cool       <= w_cool_nxt;
            r_cpu_rvalid <= w_gnt_cpu & ~bus.cpu_we;
            r_spr_rvalid <= w_gnt_spr & ~bus.spr_we;
        end
    end

    assign bus.cpu_gnt   = w_gnt_cpu;
    assign bus.spr_gnt   = w_gnt_spr;
    assign bus.cpu_stall = bus.cpu_req & ~w_gnt_cpu;
    assign bus.ram_en    = w_gnt_cpu | w_gnt_spr;

    // RAM pins are zero whenever nobody is granted.
    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (w_gnt_cpu) begin
            bus.ram_we   = bus.cpu_we;
            bus.ram_addr = bus.cpu_addr;
            bus.ram_din  = bus.cpu_wdata;
        end else if (w_gnt_spr) begin
            bus.ram_we   = bus.spr_we;
            bus.ram_addr = bus.spr_addr;
            bus.ram_din  = bus.spr_wdata;
        end
    end

    assign bus.cpu_rvalid    = r_cpu_rvalid;
    assign bus.spr_rvalid    = r_spr_rvalid;
    assign bus.cpu_rdata     = bus.ram_dout;
    assign bus.spr_rdata     = bus.ram_dout;
    assign bus.dbg_state     = r_state;
    assign bus.dbg_burst_cnt = DBG_CNT_W'(r_burst_cnt);

endmodule
